aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_key_expand.sv | 193 +++++++++++++++++++
 tb/tb_aes_key_expand.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand -- AES-128 key schedule generator.
//
// Loads a 128-bit cipher key on start and emits the eleven round keys
// (round 0 = the key itself) one at a time over a valid/ready handshake.
// Word-serial by default: one new schedule word per GEN cycle through a
// single SubWord unit of four S-boxes.
//
// Build option: define AES_KEY_EXPAND_FAST_EN to compute a whole round
// (four chained XORs, same SubWord unit) in a single GEN cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     load key_in and begin expansion (sampled only in IDLE)
//   key_in    128-bit cipher key, [127:96] = w0 ... [31:0] = w3
//   busy      high whenever the controller is not IDLE
//   rk_valid  round key present on rk_data/rk_round
//   rk_ready  consumer accepts the round key (only looked at in OUT)
//   rk_round  round index 0..10 of rk_data
//   rk_data   round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   done      one-cycle pulse after the round-10 handshake

module aes_key_expand_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  // Forward AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte x sits at bit 8*(255-x)+7 downward; {~x, 3'b111} is that index.
  logic [10:0] w_idx;
  assign w_idx = {~i_a, 3'b111};
  assign o_s   = SBOX[w_idx -: 8];
endmodule

module aes_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         done
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GEN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t       r_state;
  logic [31:0]  r_w [4];   // sliding window w[i-4] .. w[i-1]
  logic [7:0]   r_rcon;
  logic [1:0]   r_wcnt;    // word position within the round being built
  logic [3:0]   r_round;
  logic [127:0] r_rk_data;
  logic         r_valid;
  logic         r_done;

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_temp;
  logic [31:0] w_new0;
  logic [7:0]  w_rcon_next;

  // Single SubWord unit shared by every round.
  assign w_rot = {r_w[3][23:0], r_w[3][31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_key_expand_sbox u_sbox (
      .i_a (w_rot[8*g +: 8]),
      .o_s (w_sub[8*g +: 8])
    );
  end

  // The fast build keeps r_wcnt at 0, so this mux always picks SubWord there.
  assign w_temp = (r_wcnt == 2'd0) ? (w_sub ^ {r_rcon, 24'h000000}) : r_w[3];
  assign w_new0 = r_w[0] ^ w_temp;

  // xtime: multiply by x in GF(2^8) modulo 0x11b.
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

`ifdef AES_KEY_EXPAND_FAST_EN
  logic [31:0] w_new1;
  logic [31:0] w_new2;
  logic [31:0] w_new3;
  assign w_new1 = r_w[1] ^ w_new0;
  assign w_new2 = r_w[2] ^ w_new1;
  assign w_new3 = r_w[3] ^ w_new2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      for (int unsigned k = 0; k < 4; k++) r_w[k] <= '0;
      r_rcon    <= 8'h01;
      r_wcnt    <= '0;
      r_round   <= '0;
      r_rk_data <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Key captured on the start edge so key_in is never looked at
          // outside IDLE.
          if (start) begin
            r_w[0]  <= key_in[127:96];
            r_w[1]  <= key_in[95:64];
            r_w[2]  <= key_in[63:32];
            r_w[3]  <= key_in[31:0];
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_rcon    <= 8'h01;
          r_wcnt    <= '0;
          r_round   <= '0;
          r_rk_data <= {r_w[0], r_w[1], r_w[2], r_w[3]};
          r_valid   <= 1'b1;
          r_state   <= S_OUT;
        end
        S_GEN: begin
`ifdef AES_KEY_EXPAND_FAST_EN
          r_w[0]    <= w_new0;
          r_w[1]    <= w_new1;
          r_w[2]    <= w_new2;
          r_w[3]    <= w_new3;
          r_rk_data <= {w_new0, w_new1, w_new2, w_new3};
          r_round   <= r_round + 4'd1;
          r_rcon    <= w_rcon_next;
          r_valid   <= 1'b1;
          r_state   <= S_OUT;
`else
          r_w[0] <= r_w[1];
          r_w[1] <= r_w[2];
          r_w[2] <= r_w[3];
          r_w[3] <= w_new0;
          r_wcnt <= r_wcnt + 2'd1;
          if (r_wcnt == 2'd3) begin
            // Window after this edge is the completed round.
            r_rk_data <= {r_w[1], r_w[2], r_w[3], w_new0};
            r_round   <= r_round + 4'd1;
            r_rcon    <= w_rcon_next;
            r_valid   <= 1'b1;
            r_state   <= S_OUT;
          end
`endif
        end
        S_OUT: begin
          if (rk_ready) begin
            r_valid <= 1'b0;
            if (r_round == 4'd10) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_GEN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign rk_valid = r_valid;
  assign rk_round = r_round;
  assign rk_data  = r_rk_data;
  assign done     = r_done;
endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  logic         done;

`ifdef AES_KEY_EXPAND_FAST_EN
  localparam int EXP_GAP = 1;
  localparam int EXP_T10 = 21;
  localparam int RST_AT  = 8;
`else
  localparam int EXP_GAP = 4;
  localparam int EXP_T10 = 51;
  localparam int RST_AT  = 18;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] got [0:11];
  int           got_cyc [0:11];
  int           n_got;

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_data  (rk_data),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one expansion, recording each round key on its first valid cycle.
  // bp_round: round held with rk_ready=0 for 8 cycles (-1 = none).
  // inj_round: round during which a competing start is pulsed (-1 = none).
  task automatic run_expand(input logic [127:0] key, input int bp_round,
                            input int inj_round, input bit chk_t10);
    int cyc;
    int gap;
    int held;
    bit in_round;
    bit hs;
    bit fin;
    logic [127:0] hd;
    logic [3:0]   hr;
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b1;
    tick();
    start  = 1'b0;
    key_in = ~key;
    cyc = 0; gap = 0; held = 0; in_round = 1'b0; fin = 1'b0; n_got = 0;
    hd = '0; hr = '0;
    while (!fin && cyc < 400) begin
      hs = 1'b0;
      chk("done_early", {127'd0, done}, 128'd0);
      if (rk_valid) begin
        if (!in_round) begin
          in_round = 1'b1;
          held     = 0;
          hd       = rk_data;
          hr       = rk_round;
          chk("round_idx", {124'd0, rk_round}, 128'(n_got));
          if (n_got > 0) chk("gap", 128'(gap), 128'(EXP_GAP));
          if (n_got < 11) begin
            got[n_got]     = rk_data;
            got_cyc[n_got] = cyc;
          end
          if (int'(rk_round) == inj_round) begin
            chk("busy_inj", {127'd0, busy}, 128'd1);
            start  = 1'b1;
            key_in = OTHER_KEY;
          end
        end else begin
          chk("hold_data", rk_data, hd);
          chk("hold_round", {124'd0, rk_round}, {124'd0, hr});
        end
        if (int'(hr) == bp_round && held < 8) begin
          rk_ready = 1'b0;
          held++;
        end else begin
          rk_ready = 1'b1;
          hs = 1'b1;
        end
      end else begin
        if (in_round) chk("valid_drop", {127'd0, rk_valid}, 128'd1);
        gap++;
      end
      tick();
      cyc++;
      start = 1'b0;
      if (hs) begin
        in_round = 1'b0;
        gap = 0;
        n_got++;
        if (hr == 4'd10) fin = 1'b1;
      end
    end
    chk("finished", {127'd0, fin}, 128'd1);
    if (fin) begin
      chk("nkeys", 128'(n_got), 128'd11);
      chk("done_pulse", {127'd0, done}, 128'd1);
      chk("busy_at_done", {127'd0, busy}, 128'd0);
      chk("valid_at_done", {127'd0, rk_valid}, 128'd0);
      if (chk_t10) chk("t10_cycle", 128'(got_cyc[10]), 128'(EXP_T10));
      tick();
      chk("done_clear", {127'd0, done}, 128'd0);
      chk("idle_after", {127'd0, busy}, 128'd0);
    end
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    tick();
    tick();
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_round", {124'd0, rk_round}, 128'd0);
    chk("rst_data", rk_data, 128'd0);
    rst_n = 1'b1;
    rk_ready = 1'b1;
    tick();
    tick();
    chk("idle_ready_ignored", {126'd0, busy, rk_valid}, 128'd0);

    // FIPS-197 key, consumer always ready.
    run_expand(FIPS_KEY, -1, -1, 1'b1);
    for (int r = 0; r <= 10; r++) chk($sformatf("fips_r%0d", r), got[r], FIPS_RK[r]);

    // Backpressure on round 3 and a competing start during round 5.
    run_expand(FIPS_KEY, 3, 5, 1'b0);
    for (int r = 0; r <= 10; r++) chk($sformatf("bp_r%0d", r), got[r], FIPS_RK[r]);

    // Reset during GEN of round 4.
    key_in = FIPS_KEY; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < RST_AT; c++) tick();
    chk("busy_mid", {127'd0, busy}, 128'd1);
    chk("gen_mid", {127'd0, rk_valid}, 128'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", {127'd0, busy}, 128'd0);
    chk("mrst_valid", {127'd0, rk_valid}, 128'd0);
    chk("mrst_done", {127'd0, done}, 128'd0);
    chk("mrst_round", {124'd0, rk_round}, 128'd0);
    chk("mrst_data", rk_data, 128'd0);
    vcount = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (rk_valid || busy) vcount++;
    end
    chk("quiet_after_rst", 128'(vcount), 128'd0);

    // Zero key after the abandoned run.
    run_expand('0, -1, -1, 1'b1);
    chk("zero_r0", got[0], 128'd0);
    chk("zero_r1", got[1], ZERO_R1);
    chk("zero_r2", got[2], ZERO_R2);
    chk("zero_r10", got[10], ZERO_R10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
